// File: rtl/filter_pkg.sv
// Shared types and defaults for the kernel filter datapath.
package filter_pkg;

    localparam int KERNEL_SIZE_DEFAULT = 3;
    localparam int DATA_SIZE_DEFAULT   = 8;

    typedef logic [DATA_SIZE_DEFAULT-1:0] pixel_t;
    typedef pixel_t [0:KERNEL_SIZE_DEFAULT-1][0:KERNEL_SIZE_DEFAULT-1] window_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM
    } wlb_state_t;

endpackage

// File: rtl/window_line_buffer_if.sv
// Pixel-in / window-out bundle between the line buffer and its neighbours.
interface window_line_buffer_if #(
    parameter int DATA_SIZE   = filter_pkg::DATA_SIZE_DEFAULT,
    parameter int KERNEL_SIZE = filter_pkg::KERNEL_SIZE_DEFAULT
);

    // i_valid has no ready: every i_valid beat is consumed in the cycle it is
    // presented, and o_valid is a single-cycle pulse that the sink must take.
    logic                                                 i_valid;
    logic                                                 i_sof;
    logic [DATA_SIZE-1:0]                                 i_data;
    logic                                                 o_valid;
    logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_SIZE-1:0] o_window;
    logic                                                 o_eof;
    logic                                                 o_busy;
    filter_pkg::wlb_state_t                               dbg_state;

    modport master (
        output i_valid, i_sof, i_data,
        input  o_valid, o_window, o_eof, o_busy, dbg_state
    );

    modport slave (
        input  i_valid, i_sof, i_data,
        output o_valid, o_window, o_eof, o_busy, dbg_state
    );

endinterface

// File: rtl/window_line_buffer_line_ram.sv
// One image line of storage: combinational read, synchronous write,
// a same-address read during a write returns the old contents.
module line_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign o_rdata = mem[i_addr];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/window_line_buffer.sv
// Buffers two image lines and emits a 3x3 window per pixel once the window
// lies fully inside the frame.
module window_line_buffer #(
    parameter int DATA_SIZE   = filter_pkg::DATA_SIZE_DEFAULT,
    parameter int KERNEL_SIZE = filter_pkg::KERNEL_SIZE_DEFAULT,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 16
) (
    input logic                  i_clk,
    input logic                  i_nrst,
    window_line_buffer_if.slave  bus
);

    import filter_pkg::*;

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    typedef logic [DATA_SIZE-1:0] pix_t;

    if (KERNEL_SIZE != 3) begin : g_bad_kernel
        $error("window_line_buffer supports KERNEL_SIZE == 3 only");
    end
    if (IMG_WIDTH < KERNEL_SIZE || IMG_HEIGHT < KERNEL_SIZE) begin : g_bad_image
        $error("window_line_buffer needs an image at least KERNEL_SIZE on each side");
    end

    wlb_state_t      state;
    logic [XW-1:0]   x;
    logic [XW-1:0]   x_cur;
    logic [YW-1:0]   y;
    logic [YW-1:0]   y_cur;
    pix_t            mem0_rd;
    pix_t            mem1_rd;
    pix_t [0:2]      col;
    pix_t [0:2][0:1] hist;
    logic            accept;
    logic            emit;
    logic            last_col;
    logic            last_px;

    // A sof beat is pixel (0,0) regardless of where the counters stand.
    always_comb begin
        accept   = bus.i_valid && (bus.i_sof || state != IDLE);
        x_cur    = bus.i_sof ? '0 : x;
        y_cur    = bus.i_sof ? '0 : y;
        col[0]   = mem1_rd;
        col[1]   = mem0_rd;
        col[2]   = bus.i_data;
        last_col = (x_cur == X_LAST);
        last_px  = last_col && (y_cur == Y_LAST);
        emit     = (x_cur >= XW'(2)) && (y_cur >= YW'(2));
    end

    line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_SIZE)) u_mem0 (
        .i_clk   (i_clk),
        .i_we    (accept),
        .i_addr  (x_cur),
        .i_wdata (bus.i_data),
        .o_rdata (mem0_rd)
    );

    line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_SIZE)) u_mem1 (
        .i_clk   (i_clk),
        .i_we    (accept),
        .i_addr  (x_cur),
        .i_wdata (mem0_rd),
        .o_rdata (mem1_rd)
    );

    assign bus.dbg_state = state;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            hist         <= '0;
            bus.o_valid  <= 1'b0;
            bus.o_eof    <= 1'b0;
            bus.o_busy   <= 1'b0;
            bus.o_window <= '0;
        end else begin
            bus.o_valid <= 1'b0;
            bus.o_eof   <= 1'b0;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    hist[r][0] <= hist[r][1];
                    hist[r][1] <= col[r];
                end
                // The output register only moves on a real window, so it holds otherwise.
                if (emit) begin
                    bus.o_valid <= 1'b1;
                    bus.o_eof   <= last_px;
                    for (int r = 0; r < 3; r++) begin
                        bus.o_window[r] <= {hist[r][0], hist[r][1], col[r]};
                    end
                end
                if (last_px) begin
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                    x          <= '0;
                    y          <= '0;
                end else begin
                    bus.o_busy <= 1'b1;
                    if (last_col) begin
                        x <= '0;
                        y <= y_cur + YW'(1);
                    end else begin
                        x <= x_cur + XW'(1);
                        y <= y_cur;
                    end
                    if (last_col && y_cur == YW'(1)) begin
                        state <= STREAM;
                    end else if (bus.i_sof) begin
                        state <= FILL;
                    end
                end
            end
        end
    end

endmodule
